fir_tap_feeder: RTL

- Producer side of the FIR MAC datapath.
- Accepts a serial sample stream on a valid/ready handshake and shifts each sample into an NUM_REGS-deep tap delay line.
- Presents the taps and a coefficient register bank as parallel arrays to the combinational MAC, then captures the MAC result and returns it on an output valid/ready handshake.
- Sits between the sample source (DMA/bus front end) and the mac instance.

---
 rtl/fir_tap_feeder.sv | 116 +++++++++++
 1 files changed

// File: rtl/fir_tap_feeder.sv
// Sample intake, tap delay line and coefficient bank feeding an external combinational MAC.
// One sample per 3 cycles at best: accept, settle, then hold the result until resultReady; no new sample is taken while a result is pending.
module fir_tap_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_WIDTH-1:0]                sampleIn,
    input  logic                                 sampleValid,
    output logic                                 sampleReady,
    input  logic                                 coefWe,
    input  logic [$clog2(NUM_REGS)-1:0]          coefAddr,
    input  logic [DATA_WIDTH-1:0]                coefData,
    input  logic                                 flush,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  pDataOut,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  coefsOut,
    input  logic [DATA_WIDTH-1:0]                macResult,
    output logic [DATA_WIDTH-1:0]                resultOut,
    output logic                                 resultValid,
    input  logic                                 resultReady,
    output logic                                 primed
);

    localparam int CNT_W = $clog2(NUM_REGS) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        OUTPUT
    } state_t;

    state_t                               state_q, state_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  taps_q, taps_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  coefs_q, coefs_d;
    logic [DATA_WIDTH-1:0]                result_q, result_d;
    logic                                 result_vld_q, result_vld_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic                                 primed_q, primed_d;

    always_comb begin
        state_d      = state_q;
        taps_d       = taps_q;
        coefs_d      = coefs_q;
        result_d     = result_q;
        result_vld_d = result_vld_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (sampleValid) begin
                    taps_d  = {taps_q[NUM_REGS-2:0], sampleIn};
                    cnt_d   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                result_d     = macResult;
                result_vld_d = 1'b1;
                state_d      = OUTPUT;
            end
            OUTPUT: begin
                if (resultReady) begin
                    result_vld_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A coefficient write lands before COMPUTE, so a same-edge sample sees it.
        if (state_q == IDLE && coefWe) begin
            coefs_d[coefAddr] = coefData;
        end

        if (flush) begin
            taps_d       = '0;
            cnt_d        = '0;
            result_d     = result_q;
            result_vld_d = 1'b0;
            state_d      = IDLE;
        end

        primed_d = (cnt_d == CNT_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            taps_q       <= '0;
            coefs_q      <= '0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
            cnt_q        <= '0;
            primed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            taps_q       <= taps_d;
            coefs_q      <= coefs_d;
            result_q     <= result_d;
            result_vld_q <= result_vld_d;
            cnt_q        <= cnt_d;
            primed_q     <= primed_d;
        end
    end

    // Ready is forced low for the whole time reset is held, even though state reads IDLE.
    assign sampleReady = (state_q == IDLE) && !rst;
    assign pDataOut    = taps_q;
    assign coefsOut    = coefs_q;
    assign resultOut   = result_q;
    assign resultValid = result_vld_q;
    assign primed      = primed_q;

endmodule
